mem_load_store_unit: RTL and testbench
======================================

Name: mem_load_store_unit

Overview:
- Pipeline-side front end to the word-addressed data memory; sits between the MEM stage and the memory block.
- Accepts byte-addressed MIPS loads/stores (byte, half, word) and sequences the memory's start/valid handshake.
- Extracts and sign- or zero-extends sub-word loads, and performs read-modify-write for sb/sh.
- Reports misalignment, out-of-range address and memory timeout as a response error code.

Parameters:
- WORD_SIZE, 32, datapath width; byte-lane logic is defined for 32 only.
- MEMORY_SIZE, 1024, number of words in the attached memory; word index >= MEMORY_SIZE is invalid.
- TIMEOUT_CYCLES, 8, cycles spent in READ_WAIT without mem_valid before aborting.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  zero-extend loads (lbu/lhu); ignored for stores and words.
- req_address  in  WORD_SIZE  byte address.
- req_wdata  in  WORD_SIZE  store data; the low 8/16/32 bits are used.
- resp_valid  out  1  one-cycle pulse when the operation completes.
- resp_data  out  WORD_SIZE  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  out  2  0 = ok, 1 = misaligned or illegal size, 2 = invalid address, 3 = timeout.
- mem_start  out  1  start strobe to memory; the memory acts on its rising edge.
- mem_write_enabled  out  1  memory write enable.
- mem_address  out  WORD_SIZE  word index = {2'b00, addr[31:2]}.
- mem_input_data  out  WORD_SIZE  word to write.
- mem_valid  in  1  memory read-data valid.
- mem_output_data  in  WORD_SIZE  memory read word.
- mem_err_invalid_address  in  1  memory address error.

Behaviour:
- Reset: state = IDLE, all outputs 0 except req_ready = 1. Reset in any state aborts the operation: no resp_valid, mem_start low on the next cycle, memory contents are not protected from a write already started.
- Request fields are registered on accept. mem_address and mem_input_data are driven from registers. mem_start and mem_write_enabled are Moore outputs of the state.
- Byte order is big-endian:
  - byte k = word[31-8k : 24-8k];
  - half at addr[1] = 0 is [31:16], at addr[1] = 1 is [15:0].
- Accept-time checks, in priority order:
  1. req_size = 11, or a half with addr[0] = 1, or a word with addr[1:0] != 0 -> DONE with err 1.
  2. Word index >= MEMORY_SIZE -> DONE with err 2.
  3. In both error cases no mem_start pulse is issued.
- States:
  - IDLE: on accept, a load or sub-word store goes to READ_ISSUE; a word store goes to WRITE_ISSUE.
  - READ_ISSUE: mem_start = 1, write enable = 0, one cycle -> READ_WAIT.
  - READ_WAIT: mem_start = 0, wait counter increments. Exits:
    - mem_err_invalid_address -> DONE, err 2;
    - mem_valid -> capture mem_output_data; a load goes to DONE, a sub-word store merges the new lane into the captured word and goes to WRITE_ISSUE;
    - counter reaches TIMEOUT_CYCLES -> DONE, err 3.
    - mem_valid is sampled only here, never in READ_ISSUE, because a stale valid from a prior read can remain high.
  - WRITE_ISSUE: mem_start = 1, write enable = 1, input data = merged or full word, one cycle -> WRITE_RELEASE.
  - WRITE_RELEASE: mem_start = 0, write enable held at 1, one cycle -> DONE.
  - DONE: resp_valid = 1 for one cycle with resp_data/resp_err -> IDLE.
- Latency counts cycles after the accept cycle to resp_valid: load 3, word store 3, sub-word store 5, accept-time error 1.
- Back-to-back: the earliest next accept is the cycle after DONE. mem_start is therefore always low for at least one cycle between pulses.
- Loads: byte/half are sign-extended unless req_unsigned. A word load is returned as-is.

Test Plan:
1. Preload word[4] = 0x8899AABB; lw 0x10 -> resp_data 0x8899AABB, err 0, resp_valid 3 cycles after accept, exactly one mem_start pulse with write enable = 0.
2. lb 0x13 -> 0xFFFFFFBB; lbu 0x13 -> 0x000000BB; lh 0x12 -> 0xFFFFAABB; lhu 0x10 -> 0x00008899; issued back-to-back, each 3 cycles.
3. sb 0x11 with wdata 0x00000055 -> word[4] = 0x8855AABB; resp_valid 5 cycles after accept; then sh 0x12 with 0x1234 -> word[4] = 0x88551234.
4. lh 0x11 -> err 1; size 11 -> err 1; lw 0x1000 (index 1024) -> err 2; each with resp_valid 1 cycle after accept, mem_start never rises, memory unchanged.
5. Memory stub holding mem_valid = 0: lw 0x10 -> err 3 after 8 cycles in READ_WAIT, resp_data 0; the next request proceeds normally.
6. Assert reset during WRITE_ISSUE of sb 0x11 -> next cycle state IDLE, req_ready = 1, mem_start = 0, no resp_valid; a following lw 0x10 returns the stored word correctly.

Source files
------------

// File: rtl/mem_load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed memory: lane extract, sign/zero extend, sb/sh read-modify-write.
// Latency from accept: load 3, sw 3, sb/sh 5, accept-time error 1; one request in flight, req_ready is low from accept until DONE ends.
module mem_load_store_unit #(
   parameter int WORD_SIZE      = 32,
   parameter int MEMORY_SIZE    = 1024,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [WORD_SIZE-1:0] req_address,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [WORD_SIZE-1:0] resp_data,
   output logic [1:0]           resp_err,
   output logic                 mem_start,
   output logic                 mem_write_enabled,
   output logic [WORD_SIZE-1:0] mem_address,
   output logic [WORD_SIZE-1:0] mem_input_data,
   input  logic                 mem_valid,
   input  logic [WORD_SIZE-1:0] mem_output_data,
   input  logic                 mem_err_invalid_address
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, READ_ISSUE, READ_WAIT, WRITE_ISSUE, WRITE_RELEASE, DONE
   } state_t;

   state_t               state;
   logic                 op_write;
   logic [1:0]           op_size;
   logic                 op_unsigned;
   logic [1:0]           op_lane;
   logic [15:0]          op_wdata;
   logic [CNT_W-1:0]     wait_cnt;

   logic                 misaligned;
   logic                 out_of_range;
   logic [WORD_SIZE-1:0] word_index;

   assign word_index   = {2'b00, req_address[WORD_SIZE-1:2]};
   assign misaligned   = (req_size == 2'b11) ||
                         (req_size == 2'b01 && req_address[0]) ||
                         (req_size == 2'b10 && req_address[1:0] != 2'b00);
   assign out_of_range = word_index >= WORD_SIZE'(MEMORY_SIZE);

   // Big-endian lanes: byte 0 is the most significant byte of the word.
   function automatic logic [WORD_SIZE-1:0] extract(input logic [WORD_SIZE-1:0] w,
                                                    input logic [1:0] size,
                                                    input logic [1:0] lane,
                                                    input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = lane[1] ? w[15:0] : w[31:16];
      case (size)
         2'b00:   extract = {{24{b[7] & ~uns}}, b};
         2'b01:   extract = {{16{h[15] & ~uns}}, h};
         default: extract = w;
      endcase
   endfunction

   function automatic logic [WORD_SIZE-1:0] merge(input logic [WORD_SIZE-1:0] w,
                                                  input logic [1:0] size,
                                                  input logic [1:0] lane,
                                                  input logic [15:0] d);
      logic [WORD_SIZE-1:0] m;
      m = w;
      if (size == 2'b01) begin
         if (lane[1]) m[15:0]  = d;
         else         m[31:16] = d;
      end else begin
         case (lane)
            2'd0:    m[31:24] = d[7:0];
            2'd1:    m[23:16] = d[7:0];
            2'd2:    m[15:8]  = d[7:0];
            default: m[7:0]   = d[7:0];
         endcase
      end
      merge = m;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         req_ready         <= 1'b1;
         resp_valid        <= 1'b0;
         resp_data         <= '0;
         resp_err          <= 2'd0;
         mem_start         <= 1'b0;
         mem_write_enabled <= 1'b0;
         mem_address       <= '0;
         mem_input_data    <= '0;
         op_write          <= 1'b0;
         op_size           <= 2'b00;
         op_unsigned       <= 1'b0;
         op_lane           <= 2'b00;
         op_wdata          <= '0;
         wait_cnt          <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               req_ready      <= 1'b0;
               op_write       <= req_write;
               op_size        <= req_size;
               op_unsigned    <= req_unsigned;
               op_lane        <= req_address[1:0];
               op_wdata       <= req_wdata[15:0];
               mem_address    <= word_index;
               mem_input_data <= req_wdata;
               resp_data      <= '0;
               resp_err       <= 2'd0;
               if (misaligned) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 2'd1;
               end else if (out_of_range) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 2'd2;
               end else if (req_write && req_size == 2'b10) begin
                  state             <= WRITE_ISSUE;
                  mem_start         <= 1'b1;
                  mem_write_enabled <= 1'b1;
               end else begin
                  state     <= READ_ISSUE;
                  mem_start <= 1'b1;
               end
            end
            READ_ISSUE: begin
               state     <= READ_WAIT;
               mem_start <= 1'b0;
               wait_cnt  <= '0;
            end
            // mem_valid may still be high from an earlier read, so it is only trusted here.
            READ_WAIT: begin
               if (mem_err_invalid_address) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 2'd2;
               end else if (mem_valid) begin
                  if (op_write) begin
                     state             <= WRITE_ISSUE;
                     mem_input_data    <= merge(mem_output_data, op_size, op_lane, op_wdata);
                     mem_start         <= 1'b1;
                     mem_write_enabled <= 1'b1;
                  end else begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                     resp_data  <= extract(mem_output_data, op_size, op_lane, op_unsigned);
                  end
               end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                  resp_err   <= 2'd3;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WRITE_ISSUE: begin
               state     <= WRITE_RELEASE;
               mem_start <= 1'b0;
            end
            WRITE_RELEASE: begin
               state             <= DONE;
               mem_write_enabled <= 1'b0;
               resp_valid        <= 1'b1;
            end
            DONE: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: begin
               state             <= IDLE;
               req_ready         <= 1'b1;
               resp_valid        <= 1'b0;
               mem_start         <= 1'b0;
               mem_write_enabled <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_load_store_unit.sv
// Scoreboard bench for mem_load_store_unit with a behavioural word memory that acts on the rising edge of mem_start.
module tb_mem_load_store_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_address = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [1:0]  resp_err;
   logic        mem_start;
   logic        mem_write_enabled;
   logic [31:0] mem_address;
   logic [31:0] mem_input_data;
   logic        mem_valid;
   logic [31:0] mem_output_data;
   logic        mem_err = 1'b0;

   mem_load_store_unit dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
      .mem_start(mem_start), .mem_write_enabled(mem_write_enabled),
      .mem_address(mem_address), .mem_input_data(mem_input_data),
      .mem_valid(mem_valid), .mem_output_data(mem_output_data),
      .mem_err_invalid_address(mem_err)
   );

   always #5 clock = ~clock;

   // Memory model: read data and a sticky valid appear one cycle after a rising mem_start.
   logic [31:0] mem [0:1023];
   logic        mv = 1'b0;
   logic        ms_q = 1'b0;
   logic        stall = 1'b0;
   assign mem_valid = mv & ~stall;

   always @(posedge clock) begin
      if (mem_start && !ms_q) begin
         if (mem_write_enabled) mem[mem_address[9:0]] <= mem_input_data;
         else begin
            mv              <= 1'b1;
            mem_output_data <= mem[mem_address[9:0]];
         end
      end
      ms_q <= mem_start;
   end

   typedef struct {
      logic [31:0] data;
      logic [1:0]  err;
      int          lat;
      int          starts;
      int          wrs;
      logic [31:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   errors = 0;
   int   checks = 0;
   int   ncyc = 0;
   int   starts = 0;
   int   wrs = 0;
   logic ms_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every resp_valid.
   always @(negedge clock) begin
      if (!reset) begin
         if (req_valid && req_ready) begin
            acc_q.push_back(ncyc);
            starts = 0;
            wrs    = 0;
         end
         if (mem_start && !ms_prev) begin
            starts++;
            if (mem_write_enabled) wrs++;
            if (exp_q.size() > 0) chk("mem_address", mem_address, exp_q[0].addr);
         end
         if (resp_valid) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               chk("unexpected resp_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               int   a;
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk("resp_data", resp_data, e.data);
               chk("resp_err", 32'(resp_err), 32'(e.err));
               chk("latency", 32'(ncyc - a), 32'(e.lat));
               chk("start pulses", 32'(starts), 32'(e.starts));
               chk("write pulses", 32'(wrs), 32'(e.wrs));
            end
         end
      end
      ms_prev = mem_start;
      ncyc++;
   end

   task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] edata, input logic [1:0] eerr,
                         input int elat, input int est, input int ewr);
      int   n;
      exp_t e;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!req_ready) begin
         chk("req_ready timeout", 32'd0, 32'd1);
         return;
      end
      e.data = edata; e.err = eerr; e.lat = elat; e.starts = est; e.wrs = ewr;
      e.addr = {2'b00, addr[31:2]};
      exp_q.push_back(e);
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_address = addr; req_wdata = wd;
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clock);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("response timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[0] = 32'hDEADBEEF;
      mem[4] = 32'h8899AABB;

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset resp_data", resp_data, 32'd0);
      chk("reset resp_err", 32'(resp_err), 32'd0);
      chk("reset mem_start", 32'(mem_start), 32'd0);
      chk("reset mem_we", 32'(mem_write_enabled), 32'd0);
      chk("reset mem_address", mem_address, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Word and sub-word loads, back-to-back.
      do_req(0, 2'b10, 0, 32'h10, 0, 32'h8899AABB, 0, 3, 1, 0);
      do_req(0, 2'b00, 0, 32'h13, 0, 32'hFFFFFFBB, 0, 3, 1, 0);
      do_req(0, 2'b00, 1, 32'h13, 0, 32'h000000BB, 0, 3, 1, 0);
      do_req(0, 2'b01, 0, 32'h12, 0, 32'hFFFFAABB, 0, 3, 1, 0);
      do_req(0, 2'b01, 1, 32'h10, 0, 32'h00008899, 0, 3, 1, 0);
      drain();

      // Sub-word read-modify-write and a full word store.
      do_req(1, 2'b00, 0, 32'h11, 32'h00000055, 0, 0, 5, 2, 1);
      drain();
      chk("mem[4] after sb", mem[4], 32'h8855AABB);
      do_req(1, 2'b01, 0, 32'h12, 32'h00001234, 0, 0, 5, 2, 1);
      drain();
      chk("mem[4] after sh", mem[4], 32'h88551234);
      do_req(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 0, 0, 3, 1, 1);
      do_req(0, 2'b10, 0, 32'h20, 0, 32'hCAFEF00D, 0, 3, 1, 0);
      drain();

      // Accept-time errors: no memory traffic, one-cycle response.
      do_req(0, 2'b01, 0, 32'h11, 0, 0, 1, 1, 0, 0);
      do_req(0, 2'b11, 0, 32'h10, 0, 0, 1, 1, 0, 0);
      do_req(0, 2'b10, 0, 32'h1000, 0, 0, 2, 1, 0, 0);
      do_req(1, 2'b10, 0, 32'h1000, 32'h11111111, 0, 2, 1, 0, 0);
      do_req(1, 2'b01, 0, 32'h13, 32'h00002222, 0, 1, 1, 0, 0);
      drain();
      chk("mem[4] after errors", mem[4], 32'h88551234);
      chk("mem[0] after errors", mem[0], 32'hDEADBEEF);

      // Memory never answers: timeout after 8 cycles in READ_WAIT.
      stall = 1'b1;
      do_req(0, 2'b10, 0, 32'h10, 0, 0, 3, 10, 1, 0);
      drain();
      stall = 1'b0;
      do_req(0, 2'b00, 1, 32'h10, 0, 32'h00000088, 0, 3, 1, 0);
      drain();

      // Reset during WRITE_ISSUE of sb 0x11; the memory write still lands.
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_address = 32'h11; req_wdata = 32'h000000A7;
      @(posedge clock); #1;
      req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!(mem_start && mem_write_enabled) && n < 30);
      chk("reached WRITE_ISSUE", 32'(mem_start && mem_write_enabled), 32'd1);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("abort req_ready", 32'(req_ready), 32'd1);
      chk("abort mem_start", 32'(mem_start), 32'd0);
      chk("abort mem_we", 32'(mem_write_enabled), 32'd0);
      chk("abort resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      acc_q.delete();
      chk("mem[4] after abort", mem[4], 32'h88A71234);
      do_req(0, 2'b10, 0, 32'h10, 0, 32'h88A71234, 0, 3, 1, 0);
      drain();
      repeat (5) @(posedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
